// File: rtl/eth_rx_pkg.sv
// Shared constants, FSM encoding and CRC helper for the GMII receive frame path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package eth_rx_pkg;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam logic [47:0] ETH_BCAST    = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;
    localparam logic [31:0] CRC_POLY     = 32'h04C11DB7;

    // Bit positions inside frame_stat = {fcs_err, len_err, addr_miss}
    localparam int STAT_ADDR_MISS = 0;
    localparam int STAT_LEN_ERR   = 1;
    localparam int STAT_FCS_ERR   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } rx_state_t;

    // One byte of CRC-32 in MSB-first register form. Ethernet sends each byte
    // LSB first, so data bit 0 is folded in first; the register then holds the
    // bit-reversed view of the usual reflected CRC, giving residue C704DD7B.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] dat);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ dat[i]) begin
                c = {c[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// CRC-32 accumulator, one byte per cycle, with synchronous re-init and enable.
// Latency: o_crc reflects a byte one cycle after it is presented with i_en.
// Backpressure: none; the caller gates i_en.
module crc32_d8
    import eth_rx_pkg::*;
(
    input  logic        gmii_rx_clk,
    input  logic        sys_rst_n,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [7:0]  i_dat,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;

    // Running CRC: init wins over enable so a new frame always starts clean
    always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_crc <= 32'hFFFF_FFFF;
        end else if (i_init) begin
            r_crc <= 32'hFFFF_FFFF;
        end else if (i_en) begin
            r_crc <= crc32_byte(r_crc, i_dat);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/gmii_rx_frame_ctrl.sv
// GMII receive frame sequencer: strips preamble/SFD, frames bytes with sof/eof, reports length/address/FCS status and counts.
// Latency: a byte sampled on gmii_rxd appears on out_data two cycles later; stat_valid rides with out_eof.
// Backpressure: none; the line cannot be stalled. FCS checking is built only when RX_FCS_CHECK_EN is defined.
module gmii_rx_frame_ctrl
    import eth_rx_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_FE_C0,
    parameter int          MIN_LEN   = 64,
    parameter int          MAX_LEN   = 1518
) (
    input  logic        gmii_rx_clk,
    input  logic        sys_rst_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    input  logic        promisc,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic [15:0] frame_len,
    output logic [2:0]  frame_stat,
    output logic        stat_valid,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
);

    logic        r_in_dv;
    logic [7:0]  r_in_dat;
    rx_state_t   r_state;
    logic [7:0]  r_hold_dat;
    logic        r_hold_vld;
    logic        r_sof_pend;
    logic [15:0] r_len;
    logic [47:0] r_da;

    logic        w_len_err;
    logic        w_addr_miss;
    logic        w_fcs_err;
    logic [2:0]  w_stat;

`ifdef RX_FCS_CHECK_EN
    logic        w_crc_init;
    logic        w_crc_en;
    logic [31:0] w_crc;

    // The CRC restarts on SFD and absorbs every byte that enters the hold register
    assign w_crc_init = (r_state == PRE) && r_in_dv && (r_in_dat == ETH_SFD);
    assign w_crc_en   = (r_state == DATA) && r_in_dv;

    crc32_d8 u_crc32_d8 (
        .gmii_rx_clk (gmii_rx_clk),
        .sys_rst_n   (sys_rst_n),
        .i_init      (w_crc_init),
        .i_en        (w_crc_en),
        .i_dat       (r_in_dat),
        .o_crc       (w_crc)
    );

    assign w_fcs_err = (w_crc != CRC_RESIDUE);
`else
    assign w_fcs_err = 1'b0;
`endif

    // Status is evaluated on the eof edge, when r_len and r_da already cover the whole frame
    assign w_len_err   = (r_len < 16'(MIN_LEN)) || (r_len > 16'(MAX_LEN));
    assign w_addr_miss = (r_len < 16'd6) ||
                         (!promisc && (r_da != LOCAL_MAC) && (r_da != ETH_BCAST));

    assign w_stat[STAT_FCS_ERR]   = w_fcs_err;
    assign w_stat[STAT_LEN_ERR]   = w_len_err;
    assign w_stat[STAT_ADDR_MISS] = w_addr_miss;

    // Input register: the FSM only ever looks at the registered copy of the line
    always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_in_dv  <= 1'b0;
            r_in_dat <= 8'h00;
        end else begin
            r_in_dv  <= gmii_rx_dv;
            r_in_dat <= gmii_rxd;
        end
    end

    // Frame FSM with registered outputs; a byte leaves the hold register once the
    // next input shows whether it was the last one
    always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= IDLE;
            r_hold_dat <= 8'h00;
            r_hold_vld <= 1'b0;
            r_sof_pend <= 1'b0;
            r_len      <= 16'h0000;
            r_da       <= 48'h0;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            frame_len  <= 16'h0000;
            frame_stat <= 3'b000;
            stat_valid <= 1'b0;
            frame_cnt  <= 16'h0000;
            drop_cnt   <= 16'h0000;
        end else begin
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            stat_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (r_in_dv) begin
                        r_state <= (r_in_dat == ETH_PREAMBLE) ? PRE : DROP;
                    end
                end

                PRE: begin
                    if (!r_in_dv) begin
                        r_state <= IDLE;
                    end else if (r_in_dat == ETH_SFD) begin
                        r_state    <= DATA;
                        r_hold_vld <= 1'b0;
                        r_sof_pend <= 1'b1;
                        r_len      <= 16'h0000;
                        r_da       <= 48'h0;
                    end else if (r_in_dat != ETH_PREAMBLE) begin
                        r_state <= DROP;
                    end
                end

                DATA: begin
                    if (r_in_dv) begin
                        r_hold_dat <= r_in_dat;
                        r_hold_vld <= 1'b1;
                        if (r_len != 16'hFFFF) begin
                            r_len <= r_len + 16'd1;
                        end
                        if (r_len < 16'd6) begin
                            r_da <= {r_da[39:0], r_in_dat};
                        end
                        if (r_hold_vld) begin
                            out_valid  <= 1'b1;
                            out_data   <= r_hold_dat;
                            out_sof    <= r_sof_pend;
                            r_sof_pend <= 1'b0;
                        end
                    end else begin
                        r_state    <= IDLE;
                        r_hold_vld <= 1'b0;
                        r_sof_pend <= 1'b0;
                        if (r_hold_vld) begin
                            out_valid  <= 1'b1;
                            out_data   <= r_hold_dat;
                            out_sof    <= r_sof_pend;
                            out_eof    <= 1'b1;
                            stat_valid <= 1'b1;
                            frame_len  <= r_len;
                            frame_stat <= w_stat;
                            if (w_stat == 3'b000) begin
                                if (frame_cnt != 16'hFFFF) begin
                                    frame_cnt <= frame_cnt + 16'd1;
                                end
                            end else begin
                                if (drop_cnt != 16'hFFFF) begin
                                    drop_cnt <= drop_cnt + 16'd1;
                                end
                            end
                        end
                    end
                end

                DROP: begin
                    if (!r_in_dv) begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_rx_frame_ctrl.sv
// Directed bench for gmii_rx_frame_ctrl with a frame-level scoreboard keyed by output cycle.
// Latency: expects each frame byte two cycles after it is sampled.
// Backpressure: none.
module tb_gmii_rx_frame_ctrl;

    localparam logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_FE_C0;
    localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_01;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [7:0]  d;
        logic        sof;
        logic        eof;
        logic [15:0] len;
        logic [2:0]  stat;
        logic [15:0] fc;
        logic [15:0] dc;
    } exp_t;

    logic        gmii_rx_clk = 1'b0;
    logic        sys_rst_n   = 1'b1;
    logic        gmii_rx_dv  = 1'b0;
    logic [7:0]  gmii_rxd    = 8'h00;
    logic        promisc     = 1'b0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        out_eof;
    logic [15:0] frame_len;
    logic [2:0]  frame_stat;
    logic        stat_valid;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    gmii_rx_frame_ctrl dut (
        .gmii_rx_clk (gmii_rx_clk),
        .sys_rst_n   (sys_rst_n),
        .gmii_rx_dv  (gmii_rx_dv),
        .gmii_rxd    (gmii_rxd),
        .promisc     (promisc),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .frame_len   (frame_len),
        .frame_stat  (frame_stat),
        .stat_valid  (stat_valid),
        .frame_cnt   (frame_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #4 gmii_rx_clk = ~gmii_rx_clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    exp_t        exp_q[int];
    logic [15:0] mdl_fc = 16'h0, mdl_dc = 16'h0;
    logic [15:0] cur_fc = 16'h0, cur_dc = 16'h0;

    int          nvalid = 0, nstat = 0, nsof = 0;
    logic [15:0] last_len  = 16'h0;
    logic [2:0]  last_stat = 3'b000;
    logic [7:0]  first_dat = 8'h00;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reflected CRC-32 over a byte list, init FFFFFFFF, no final inversion
    function automatic logic [31:0] crc_refl(input byte_q_t f);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (f[i]) begin
            c = c ^ {24'h0, f[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return c;
    endfunction

    // Status a frame must earn, straight from the acceptance rules
    function automatic logic [2:0] model_stat(input byte_q_t f, input logic prm);
        logic [47:0] da;
        logic        am, le, fe;
        int          n;
        logic [31:0] r, rev;
        n  = f.size();
        da = 48'h0;
        if (n >= 6) da = {f[0], f[1], f[2], f[3], f[4], f[5]};
        am = (n < 6) || (!prm && da != LOCAL_MAC && da != BCAST);
        le = (n < 64) || (n > 1518);
        r  = crc_refl(f);
        for (int k = 0; k < 32; k++) rev[k] = r[31-k];
`ifdef RX_FCS_CHECK_EN
        fe = (rev != 32'hC704DD7B);
`else
        fe = 1'b0;
        if (rev == 32'h0) fe = 1'b0;
`endif
        return {fe, le, am};
    endfunction

    task automatic build_frame(input logic [47:0] da, input int len, input bit flip, output byte_q_t f);
        logic [31:0] fcs;
        byte_q_t     q;
        q = {};
        for (int i = 0; i < 6; i++) q.push_back(da[47-8*i -: 8]);
        q.push_back(8'h00); q.push_back(8'h11); q.push_back(8'h22);
        q.push_back(8'h33); q.push_back(8'h44); q.push_back(8'h55);
        q.push_back(8'h08); q.push_back(8'h00);
        while (q.size() < len - 4) q.push_back(8'(q.size()) ^ 8'hA5);
        fcs = ~crc_refl(q);
        q.push_back(fcs[7:0]);   q.push_back(fcs[15:8]);
        q.push_back(fcs[23:16]); q.push_back(fcs[31:24]);
        if (flip) q[20] = q[20] ^ 8'h08;
        f = q;
    endtask

    task automatic tick(input logic dv, input logic [7:0] d);
        @(posedge gmii_rx_clk);
        #1;
        gmii_rx_dv = dv;
        gmii_rxd   = d;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00);
    endtask

    task automatic clear_mon();
        nvalid = 0; nstat = 0; nsof = 0;
    endtask

    // Drive preamble+SFD+frame; schedule every expected output byte; optionally
    // pull reset while byte abort_at would be driven
    task automatic send_frame(input byte_q_t f, input int npre, input int gap, input int abort_at);
        exp_t       e;
        logic [2:0] st;
        int         n;
        n  = f.size();
        st = model_stat(f, promisc);
        if (st == 3'b000) mdl_fc++; else mdl_dc++;
        repeat (npre) tick(1'b1, 8'h55);
        tick(1'b1, 8'hD5);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                @(posedge gmii_rx_clk);
                #1;
                sys_rst_n  = 1'b0;
                gmii_rx_dv = 1'b0;
                gmii_rxd   = 8'h00;
                exp_q.delete();
                mdl_fc = 16'h0; mdl_dc = 16'h0;
                cur_fc = 16'h0; cur_dc = 16'h0;
                #1;
                check("reset_midframe_outputs",
                      {out_valid, out_data, out_sof, out_eof, stat_valid, frame_len, frame_stat},
                      {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0, 3'b000});
                check("reset_midframe_counters", {frame_cnt, drop_cnt}, 32'h0);
                idle(3);
                sys_rst_n = 1'b1;
                idle(gap);
                return;
            end
            tick(1'b1, f[i]);
            e.d    = f[i];
            e.sof  = (i == 0);
            e.eof  = (i == n - 1);
            e.len  = 16'(n);
            e.stat = st;
            e.fc   = mdl_fc;
            e.dc   = mdl_dc;
            exp_q[cyc + 3] = e;
        end
        idle(gap);
    endtask

    task automatic send_raw(input byte_q_t f);
        foreach (f[i]) tick(1'b1, f[i]);
        idle(10);
    endtask

    // Per-cycle comparison against the scoreboard, plus a light monitor for literal checks
    always @(negedge gmii_rx_clk) begin : cmp
        exp_t e;
        if (exp_q.exists(cyc)) begin
            e = exp_q[cyc];
            exp_q.delete(cyc);
            check($sformatf("byte_c%0d", cyc),
                  {out_valid, out_sof, out_eof, stat_valid, out_data},
                  {1'b1, e.sof, e.eof, e.eof, e.d});
            if (e.eof) begin
                check($sformatf("stat_c%0d", cyc), {frame_len, frame_stat}, {e.len, e.stat});
                cur_fc = e.fc;
                cur_dc = e.dc;
            end
        end else begin
            check($sformatf("quiet_c%0d", cyc), {out_valid, out_sof, out_eof, stat_valid}, 4'b0000);
        end
        check($sformatf("cnt_c%0d", cyc), {frame_cnt, drop_cnt}, {cur_fc, cur_dc});
        if (out_valid) begin
            nvalid++;
            if (out_sof) begin
                nsof++;
                first_dat = out_data;
            end
        end
        if (stat_valid) begin
            nstat++;
            last_len  = frame_len;
            last_stat = frame_stat;
        end
    end

    always @(posedge gmii_rx_clk) cyc <= cyc + 1;

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        byte_q_t f, g;
        #1 sys_rst_n = 1'b0;
        #2;
        check("reset_outputs",
              {out_valid, out_data, out_sof, out_eof, stat_valid, frame_len, frame_stat, frame_cnt, drop_cnt},
              {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0, 3'b000, 16'h0, 16'h0});
        idle(3);
        sys_rst_n = 1'b1;
        idle(3);

        // 1: good 64-byte frame to the local address
        build_frame(LOCAL_MAC, 64, 1'b0, f);
        clear_mon();
        send_frame(f, 7, 12, -1);
        check("t1_valid_cycles", 48'(nvalid), 48'd64);
        check("t1_sof_count", 48'(nsof), 48'd1);
        check("t1_sof_byte", 48'(first_dat), 48'h00);
        check("t1_stat_pulses", 48'(nstat), 48'd1);
        check("t1_len", 48'(last_len), 48'd64);
        check("t1_stat", 48'(last_stat), 48'd0);
        check("t1_frame_cnt", 48'(frame_cnt), 48'd1);

        // 2: broadcast accepted, foreign unicast missed, promiscuous accepts both
        build_frame(BCAST, 64, 1'b0, f);
        send_frame(f, 7, 12, -1);
        check("t2_bcast_stat", 48'(last_stat), 48'd0);
        build_frame(OTHER_MAC, 64, 1'b0, g);
        send_frame(g, 7, 12, -1);
        check("t2_miss_stat", 48'(last_stat), 48'b001);
        check("t2_drop_cnt", 48'(drop_cnt), 48'd1);
        promisc = 1'b1;
        send_frame(f, 7, 12, -1);
        check("t2_prm_bcast_stat", 48'(last_stat), 48'd0);
        send_frame(g, 7, 12, -1);
        check("t2_prm_other_stat", 48'(last_stat), 48'd0);
        promisc = 1'b0;
        check("t2_frame_cnt", 48'(frame_cnt), 48'd4);

        // 3: runt and oversize
        build_frame(LOCAL_MAC, 60, 1'b0, f);
        send_frame(f, 7, 12, -1);
        check("t3_runt_stat", 48'(last_stat), 48'b010);
        check("t3_runt_len", 48'(last_len), 48'd60);
        build_frame(LOCAL_MAC, 1519, 1'b0, f);
        send_frame(f, 7, 12, -1);
        check("t3_giant_stat", 48'(last_stat), 48'b010);
        check("t3_giant_len", 48'(last_len), 48'd1519);
        check("t3_counts", {frame_cnt, drop_cnt}, {16'd4, 16'd3});

        // 4: one flipped payload bit
        build_frame(LOCAL_MAC, 64, 1'b1, f);
        send_frame(f, 7, 12, -1);
`ifdef RX_FCS_CHECK_EN
        check("t4_flip_stat", 48'(last_stat), 48'b100);
`else
        check("t4_flip_stat", 48'(last_stat), 48'b000);
`endif

        // 3-byte frame: too short to hold a DA
        f = {8'hFF, 8'hFF, 8'hFF};
        send_frame(f, 7, 12, -1);
        check("short_stat_low", 48'(last_stat[1:0]), 48'b11);
        check("short_len", 48'(last_len), 48'd3);

        // 5: broken preamble and a burst not starting with preamble
        clear_mon();
        build_frame(LOCAL_MAC, 64, 1'b0, f);
        g = {8'h55, 8'h55, 8'hAA, 8'h55, 8'hD5};
        g = {g, f};
        send_raw(g);
        g = {8'h00, 8'h55, 8'h55, 8'h55, 8'hD5};
        g = {g, f};
        send_raw(g);
        check("t5_no_valid", 48'(nvalid), 48'd0);
        check("t5_no_stat", 48'(nstat), 48'd0);

        // 6: reset at byte 30, then back-to-back good frames with a 1-cycle gap
        send_frame(f, 7, 12, 30);
        clear_mon();
        send_frame(f, 7, 1, -1);
        send_frame(f, 7, 12, -1);
        check("t6_stat_pulses", 48'(nstat), 48'd2);
        check("t6_valid_cycles", 48'(nvalid), 48'd128);
        check("t6_counts", {frame_cnt, drop_cnt}, {16'd2, 16'd0});

        idle(5);
        check("scoreboard_drained", 48'(exp_q.num()), 48'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
